// File: rtl/ising_pkg.sv
// Shared types and width helpers for the Ising energy engine.
package ising_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ising_state_e;

  // Signed width of one column's local field h_k.
  function automatic int unsigned field_width(input int unsigned n, input int unsigned w);
    return $clog2(n) + w + 1;
  endfunction

  // Signed width of the total energy.
  function automatic int unsigned energy_width(input int unsigned n, input int unsigned w);
    return 2 * $clog2(n) + w + 1;
  endfunction

endpackage

// File: rtl/column_reducer.sv
// Combinational local field for one J column: h = sum_i (sigma_i ? +J[i] : -J[i]).
module column_reducer import ising_pkg::*; #(
  parameter int unsigned VECTOR_SIZE     = 256,
  parameter int unsigned J_ELEMENT_WIDTH = 4,
  parameter int unsigned FIELD_WIDTH     = field_width(VECTOR_SIZE, J_ELEMENT_WIDTH)
) (
  input  logic [VECTOR_SIZE-1:0]                 sigma,
  input  logic [VECTOR_SIZE*J_ELEMENT_WIDTH-1:0] col,
  output logic [FIELD_WIDTH-1:0]                 h
);

  logic signed [J_ELEMENT_WIDTH-1:0] elem;
  logic signed [FIELD_WIDTH-1:0]     node [VECTOR_SIZE];

  // Sign-extend, conditionally negate at full field width, then reduce pairwise.
  always_comb begin
    elem = '0;
    for (int i = 0; i < int'(VECTOR_SIZE); i++) begin
      elem    = col[i*J_ELEMENT_WIDTH +: J_ELEMENT_WIDTH];
      node[i] = sigma[i] ? FIELD_WIDTH'(elem) : -FIELD_WIDTH'(elem);
    end
    for (int s = 1; s < int'(VECTOR_SIZE); s = s * 2) begin
      for (int i = 0; i < int'(VECTOR_SIZE); i = i + 2 * s) begin
        node[i] = node[i] + node[i+s];
      end
    end
    h = node[0];
  end

endmodule

// File: rtl/ising_energy_engine.sv
// Streaming Ising energy evaluator with chunked J input and a held result handshake.
module ising_energy_engine import ising_pkg::*; #(
  parameter  int unsigned VECTOR_SIZE     = 256,
  parameter  int unsigned J_ELEMENT_WIDTH = 4,
  parameter  int unsigned COLS_PER_CLK    = 4,
  localparam int unsigned NUM_CHUNKS      = VECTOR_SIZE / COLS_PER_CLK,
  localparam int unsigned FIELD_WIDTH     = field_width(VECTOR_SIZE, J_ELEMENT_WIDTH),
  localparam int unsigned ENERGY_WIDTH    = energy_width(VECTOR_SIZE, J_ELEMENT_WIDTH),
  localparam int unsigned CIDX_W          = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              start,
  input  logic [VECTOR_SIZE-1:0]                            sigma,
  input  logic [ENERGY_WIDTH-1:0]                           threshold,
  input  logic [VECTOR_SIZE*COLS_PER_CLK*J_ELEMENT_WIDTH-1:0] j_chunk,
  input  logic                                              j_valid,
  output logic                                              j_ready,
  output logic [CIDX_W-1:0]                                 chunk_idx,
  input  logic                                              abort,
  output logic                                              busy,
  output logic [ENERGY_WIDTH-1:0]                           energy,
  output logic                                              below_thr,
  output logic                                              out_valid,
  input  logic                                              out_ready
);

  localparam int unsigned COL_BITS = VECTOR_SIZE * J_ELEMENT_WIDTH;
  localparam int unsigned SEL_W    = $clog2(VECTOR_SIZE);
  localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(NUM_CHUNKS - 1);

  ising_state_e state_q, state_d;

  logic [VECTOR_SIZE-1:0]         sigma_q;
  logic signed [ENERGY_WIDTH-1:0] thr_q;
  logic signed [ENERGY_WIDTH-1:0] acc_q;
  logic signed [ENERGY_WIDTH-1:0] acc_next;
  logic signed [ENERGY_WIDTH-1:0] term_sum;
  logic                           s1_valid_q;
  logic signed [FIELD_WIDTH-1:0]  s1_term_q [COLS_PER_CLK];
  logic [FIELD_WIDTH-1:0]         h        [COLS_PER_CLK];
  logic signed [FIELD_WIDTH-1:0]  term     [COLS_PER_CLK];
  logic [SEL_W-1:0]               col_sel;
  logic                           accept;
  logic                           capture;
  logic                           last_accept;

  // One reducer per column of the chunk.
  for (genvar k = 0; k < int'(COLS_PER_CLK); k++) begin : g_col
    column_reducer #(
      .VECTOR_SIZE     (VECTOR_SIZE),
      .J_ELEMENT_WIDTH (J_ELEMENT_WIDTH),
      .FIELD_WIDTH     (FIELD_WIDTH)
    ) u_col (
      .sigma (sigma_q),
      .col   (j_chunk[k*COL_BITS +: COL_BITS]),
      .h     (h[k])
    );
  end

  // Apply the spin of each global column to its local field.
  always_comb begin
    col_sel = '0;
    for (int k = 0; k < int'(COLS_PER_CLK); k++) begin
      col_sel = SEL_W'(int'(chunk_idx) * int'(COLS_PER_CLK) + k);
      term[k] = sigma_q[col_sel] ? $signed(h[k]) : -$signed(h[k]);
    end
  end

  // Stage-2 reduction of registered terms and the next accumulator value.
  always_comb begin
    term_sum = '0;
    for (int k = 0; k < int'(COLS_PER_CLK); k++) begin
      term_sum = term_sum + ENERGY_WIDTH'(s1_term_q[k]);
    end
    acc_next = s1_valid_q ? (acc_q + term_sum) : acc_q;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d     = state_q;
    accept      = j_valid && j_ready;
    capture     = 1'b0;
    last_accept = accept && (chunk_idx == LAST_CHUNK);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN:   if (last_accept) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
      capture = 1'b0;
      accept  = 1'b0;
    end
  end

  // State, pipeline, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      j_ready    <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      energy     <= '0;
      below_thr  <= 1'b0;
      chunk_idx  <= '0;
      sigma_q    <= '0;
      thr_q      <= '0;
      acc_q      <= '0;
      s1_valid_q <= 1'b0;
      for (int k = 0; k < int'(COLS_PER_CLK); k++) s1_term_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      j_ready    <= (state_d == ST_RUN);
      busy       <= (state_d != ST_IDLE);
      out_valid  <= (state_d == ST_DONE);
      s1_valid_q <= accept;
      acc_q      <= acc_next;
      if (accept) begin
        for (int k = 0; k < int'(COLS_PER_CLK); k++) s1_term_q[k] <= term[k];
        chunk_idx <= (chunk_idx == LAST_CHUNK) ? '0 : chunk_idx + CIDX_W'(1);
      end
      if (capture) begin
        sigma_q   <= sigma;
        thr_q     <= threshold;
        acc_q     <= '0;
        chunk_idx <= '0;
      end
      if (abort) chunk_idx <= '0;
      if (state_q == ST_FLUSH && state_d == ST_DONE) begin
        energy    <= acc_next;
        below_thr <= (acc_next < thr_q);
      end
    end
  end

endmodule

// File: tb/tb_ising_energy_engine.sv
// Directed self-checking bench for ising_energy_engine (N=8, 2 cols/clk, 4-bit J).
module tb_ising_energy_engine;

  localparam int N  = 8;
  localparam int C  = 2;
  localparam int W  = 4;
  localparam int NC = N / C;
  localparam int EW = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [N-1:0]      sigma;
  logic [EW-1:0]     threshold;
  logic [N*C*W-1:0]  j_chunk;
  logic              j_valid;
  logic              j_ready;
  logic [1:0]        chunk_idx;
  logic              abort;
  logic              busy;
  logic [EW-1:0]     energy;
  logic              below_thr;
  logic              out_valid;
  logic              out_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int jm [N][N];

  ising_energy_engine #(
    .VECTOR_SIZE     (N),
    .J_ELEMENT_WIDTH (W),
    .COLS_PER_CLK    (C)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sigma     (sigma),
    .threshold (threshold),
    .j_chunk   (j_chunk),
    .j_valid   (j_valid),
    .j_ready   (j_ready),
    .chunk_idx (chunk_idx),
    .abort     (abort),
    .busy      (busy),
    .energy    (energy),
    .below_thr (below_thr),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int energy_s();
    return int'($signed(energy));
  endfunction

  function automatic logic [N*C*W-1:0] build_chunk(input int c);
    logic [N*C*W-1:0] v;
    v = '0;
    for (int k = 0; k < C; k++)
      for (int i = 0; i < N; i++)
        v[(k*N+i)*W +: W] = W'(jm[i][c*C+k]);
    return v;
  endfunction

  function automatic int ref_energy(input logic [N-1:0] s);
    int e;
    e = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        e += (s[i] ? 1 : -1) * (s[j] ? 1 : -1) * jm[i][j];
    return e;
  endfunction

  task automatic set_all_j(input int v);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) jm[i][j] = v;
  endtask

  task automatic start_eval(input logic [N-1:0] s, input int thr);
    start = 1'b1; sigma = s; threshold = EW'(thr);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer chunks with pct% valid; tracks chunk_idx against the bench's own count.
  task automatic feed(input int pct, input int nfeed);
    int got = 0;
    int guard = 0;
    while (got < nfeed && guard < 400) begin
      j_chunk = build_chunk(got % NC);
      j_valid = ($urandom_range(99) < pct);
      if (j_ready) check_eq("chunk_idx", int'(chunk_idx), got % NC);
      if (j_valid && j_ready) got++;
      @(negedge clk);
      guard++;
    end
    j_valid = 1'b0;
    if (got < nfeed) check_eq("feed_timeout", got, nfeed);
  endtask

  task automatic wait_result(input string tag);
    int guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("out_valid_cleared", int'(out_valid), 0);
    check_eq("busy_cleared", int'(busy), 0);
  endtask

  task automatic run_eval(input string tag, input logic [N-1:0] s, input int thr,
                          input int pct, input int exp_e, input int exp_b);
    start_eval(s, thr);
    feed(pct, NC);
    wait_result(tag);
    check_eq({tag, "_energy"}, energy_s(), exp_e);
    check_eq({tag, "_below"}, int'(below_thr), exp_b);
    release_result();
  endtask

  initial begin
    int exp_e;
    int cnt;
    logic [N-1:0] s_rand;

    rst_n = 1'b0; start = 1'b0; sigma = '0; threshold = '0; j_chunk = '0;
    j_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_j_ready", int'(j_ready), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_energy", energy_s(), 0);
    check_eq("rst_below", int'(below_thr), 0);
    check_eq("rst_chunk_idx", int'(chunk_idx), 0);

    // 1: all +7, full-up spins; latency counted inclusively from first acceptance cycle.
    set_all_j(7);
    start_eval(8'hFF, 0);
    check_eq("t1_j_ready", int'(j_ready), 1);
    feed(100, NC);
    check_eq("t1_flush_no_valid", int'(out_valid), 0);
    check_eq("t1_flush_j_ready", int'(j_ready), 0);
    @(negedge clk);
    check_eq("t1_valid_cycle6", int'(out_valid), 1);
    check_eq("t1_energy", energy_s(), 448);
    check_eq("t1_below", int'(below_thr), 0);
    check_eq("t1_busy", int'(busy), 1);
    release_result();

    // 2: most-negative elements must not wrap on negation.
    set_all_j(-8);
    run_eval("t2", 8'hFF, 0, 100, -512, 1);

    // 3: balanced spins cancel; threshold boundary.
    set_all_j(1);
    run_eval("t3a", 8'h0F, 0, 100, 0, 0);
    run_eval("t3b", 8'h0F, 1, 100, 0, 1);

    // 4: random J and sigma, bursty valid, result held under back-pressure.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) jm[i][j] = int'($urandom_range(15)) - 8;
    s_rand = N'($urandom);
    exp_e = ref_energy(s_rand);
    start_eval(s_rand, 3);
    feed(50, NC);
    wait_result("t4");
    for (int c = 0; c < 5; c++) begin
      check_eq("t4_hold_valid", int'(out_valid), 1);
      check_eq("t4_hold_energy", energy_s(), exp_e);
      check_eq("t4_hold_below", int'(below_thr), (exp_e < 3) ? 1 : 0);
      @(negedge clk);
    end
    release_result();

    // 5: abort mid-run, then a fresh evaluation with a new sigma.
    start_eval(8'hA5, 0);
    feed(100, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t5_abort_busy", int'(busy), 0);
    check_eq("t5_abort_idx", int'(chunk_idx), 0);
    check_eq("t5_abort_ready", int'(j_ready), 0);
    check_eq("t5_abort_valid", int'(out_valid), 0);
    exp_e = ref_energy(8'h3C);
    run_eval("t5", 8'h3C, 0, 100, exp_e, (exp_e < 0) ? 1 : 0);

    // 6: reset mid-run, then start pulsed during FLUSH is ignored.
    start_eval(8'h96, 0);
    feed(100, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("t6_rst_j_ready", int'(j_ready), 0);
    check_eq("t6_rst_busy", int'(busy), 0);
    check_eq("t6_rst_out_valid", int'(out_valid), 0);
    check_eq("t6_rst_energy", energy_s(), 0);
    check_eq("t6_rst_below", int'(below_thr), 0);
    check_eq("t6_rst_chunk_idx", int'(chunk_idx), 0);
    exp_e = ref_energy(8'h5A);
    start_eval(8'h5A, 0);
    feed(100, NC);
    start = 1'b1; sigma = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    check_eq("t6_valid", int'(out_valid), 1);
    check_eq("t6_energy", energy_s(), exp_e);
    release_result();
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid || busy) cnt++;
      @(negedge clk);
    end
    check_eq("t6_no_extra_run", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
